terminal_writer: RTL

- Character-stream front end for the 80x30 text terminal; owns the text buffer write port (text_addr/text_write/text_in) and reads back through text_out.
- Accepts ASCII bytes over a valid/ready handshake and keeps a cursor.
- Handles CR, LF, BS, auto-wrap and scroll-up by copying rows through the buffer's single address port.

---
 rtl/terminal_writer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/terminal_writer.sv
// Purpose : character-stream front end for a COLS x ROWS text buffer; cursor, CR/LF/BS, auto-wrap, scroll-up.
// Latency : printable byte or BS occupies 1 busy cycle; a scroll takes 2*(ROWS-1)*COLS + COLS cycles.
// Backpr. : char_ready is high only in IDLE; a byte offered while busy is held off until the writer returns to IDLE.
//
// Ports   : clock/reset (async, active-high); char_valid/char_data/char_ready byte input handshake;
//           text_addr/text_write/text_in buffer write port, text_out same-cycle buffer read data;
//           cursor_col/cursor_row current cursor; busy high outside IDLE.
// Option  : define TERMINAL_WRITER_CLEAR_EN to make form feed (0x0C) blank the whole screen and home the cursor.
module terminal_writer #(
   parameter int         COLS  = 80,
   parameter int         ROWS  = 30,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   input  logic [7:0]  text_out,
   output logic [11:0] text_addr,
   output logic        text_write,
   output logic [7:0]  text_in,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   localparam logic [11:0] COLS_A    = 12'(COLS);
   localparam logic [11:0] BODY_END  = 12'((ROWS - 1) * COLS);  // first cell of the bottom row
   localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

   typedef enum logic [2:0] {IDLE, PUT, SCROLL_RD, SCROLL_WR, CLEAR} state_t;

   state_t      state_q, state_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [11:0] ptr_q, ptr_d;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  hold_q, hold_d;
   logic        adv_q, adv_d;      // PUT advances the cursor (printable) or leaves it on the cell (BS)
   logic        live_q, live_d;    // keeps char_ready low until the first edge after reset release
`ifdef TERMINAL_WRITER_CLEAR_EN
   logic        home_q, home_d;    // CLEAR was started by form feed, so home the cursor when it ends
`endif

   logic        accept;
   logic        newline;
   logic [11:0] cell_addr;

   assign char_ready = live_q && (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign accept     = char_valid && char_ready;
   assign cell_addr  = 12'(row_q) * COLS_A + 12'(col_q);

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      ptr_d      = ptr_q;
      byte_d     = byte_q;
      hold_d     = hold_q;
      adv_d      = adv_q;
      live_d     = 1'b1;
`ifdef TERMINAL_WRITER_CLEAR_EN
      home_d     = home_q;
`endif
      newline    = 1'b0;
      text_addr  = 12'd0;
      text_write = 1'b0;
      text_in    = 8'd0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                  state_d = PUT;
                  byte_d  = char_data;
                  adv_d   = 1'b1;
               end else if (char_data == 8'h0D) begin
                  col_d = 7'd0;
               end else if (char_data == 8'h0A) begin
                  newline = 1'b1;
               end else if (char_data == 8'h08) begin
                  if (col_q != 7'd0) begin
                     col_d   = col_q - 7'd1;
                     byte_d  = BLANK;
                     adv_d   = 1'b0;
                     state_d = PUT;
                  end
`ifdef TERMINAL_WRITER_CLEAR_EN
               end else if (char_data == 8'h0C) begin
                  state_d = CLEAR;
                  ptr_d   = 12'd0;
                  home_d  = 1'b1;
`endif
               end
            end
         end
         PUT: begin
            text_write = 1'b1;
            text_addr  = cell_addr;
            text_in    = byte_q;
            state_d    = IDLE;
            if (adv_q) begin
               if (col_q == LAST_COL) newline = 1'b1;
               else                   col_d   = col_q + 7'd1;
            end
         end
         SCROLL_RD: begin
            // read the cell one row below; the buffer answers in the same cycle
            text_addr = ptr_q + COLS_A;
            hold_d    = text_out;
            state_d   = SCROLL_WR;
         end
         SCROLL_WR: begin
            text_addr  = ptr_q;
            text_write = 1'b1;
            text_in    = hold_q;
            ptr_d      = ptr_q + 12'd1;
            // once every row above the bottom has been copied, ptr already sits on the bottom row
            state_d    = (ptr_q + 12'd1 == BODY_END) ? CLEAR : SCROLL_RD;
         end
         CLEAR: begin
            text_addr  = ptr_q;
            text_write = 1'b1;
            text_in    = BLANK;
            ptr_d      = ptr_q + 12'd1;
            if (ptr_q == LAST_CELL) begin
               state_d = IDLE;
`ifdef TERMINAL_WRITER_CLEAR_EN
               if (home_q) begin
                  col_d  = 7'd0;
                  row_d  = 5'd0;
                  home_d = 1'b0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // shared by LF and auto-wrap: the bottom row scrolls instead of advancing
      if (newline) begin
         col_d = 7'd0;
         if (row_q == LAST_ROW) begin
            state_d = SCROLL_RD;
            ptr_d   = 12'd0;
         end else begin
            row_d = row_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         col_q   <= 7'd0;
         row_q   <= 5'd0;
         ptr_q   <= 12'd0;
         byte_q  <= 8'd0;
         hold_q  <= 8'd0;
         adv_q   <= 1'b0;
         live_q  <= 1'b0;
`ifdef TERMINAL_WRITER_CLEAR_EN
         home_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         ptr_q   <= ptr_d;
         byte_q  <= byte_d;
         hold_q  <= hold_d;
         adv_q   <= adv_d;
         live_q  <= live_d;
`ifdef TERMINAL_WRITER_CLEAR_EN
         home_q  <= home_d;
`endif
      end
   end

endmodule
